// File: rtl/ah_demux_pkg.sv
// Shared types for the packet-aware demux: FSM state, limits, per-beat sideband.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ah_demux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    DROP
  } state_t;

  localparam int MAX_EGR   = 16;
  localparam int SEL_MAX_W = $clog2(MAX_EGR);

  // Sideband carried with each beat; data stays separate because DATA_W is a parameter.
  typedef struct packed {
    logic                 last;
    logic [SEL_MAX_W-1:0] sel;
  } beat_t;

endpackage

// File: rtl/ah_demux_skid.sv
// 2-entry valid/ready skid buffer with fall-through when empty.
// Latency: 0 cycles when empty (input presented combinationally), else FIFO order.
// Backpressure: o_in_rdy is a flop (= not full next cycle); no comb path from i_out_rdy.
// Ports: clk/rst; i_in_dat/i_in_vld/o_in_rdy upstream; o_out_dat/o_out_vld/i_out_rdy downstream.
module ah_demux_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_in_dat,
  input  logic         i_in_vld,
  output logic         o_in_rdy,
  output logic [W-1:0] o_out_dat,
  output logic         o_out_vld,
  input  logic         i_out_rdy
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         r_rdy;

  logic         w_in_xfer;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_nxt;

  assign w_in_xfer = i_in_vld & r_rdy;
  // An incoming beat skips storage when nothing is queued and downstream takes it now.
  assign w_bypass  = (r_cnt == 2'd0) & i_out_rdy;
  assign w_push    = w_in_xfer & ~w_bypass;
  assign w_pop     = (r_cnt != 2'd0) & i_out_rdy;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  assign o_in_rdy  = r_rdy;
  assign o_out_vld = (r_cnt != 2'd0) | w_in_xfer;
  assign o_out_dat = (r_cnt != 2'd0) ? r_mem[r_rp] : i_in_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_rdy    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_in_dat;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/ah_demux_pkt.sv
// Registered packet-aware 1-to-N demux; select latched on first beat, bad selects dropped.
// Latency: 1 cycle ingress transfer to egr_valid; 1 beat/cycle sustained.
// Backpressure: ing_ready = !full | egr_ready[sel_out] (1 in DROP); with AH_DEMUX_SKID_EN
//   a 2-entry skid makes ing_ready a flop output.
// Ports: clk/rst; ing_data/ing_valid/ing_ready/ing_sel/ing_last ingress;
//   egr_data (flat, channel i at [i*DATA_W +: DATA_W])/egr_last/egr_valid/egr_ready egress;
//   err_sel sticky bad-select flag, err_clr synchronous clear (set wins).
// Build option: define AH_DEMUX_SKID_EN to insert the skid stage.
module ah_demux_pkt
  import ah_demux_pkg::*;
#(
  parameter int DATA_W  = 258,
  parameter int NUM_EGR = 11,
  parameter int SEL_W   = $clog2(NUM_EGR)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         ing_data,
  input  logic                      ing_valid,
  output logic                      ing_ready,
  input  logic [SEL_W-1:0]          ing_sel,
  input  logic                      ing_last,
  output logic [NUM_EGR*DATA_W-1:0] egr_data,
  output logic [NUM_EGR-1:0]        egr_last,
  output logic [NUM_EGR-1:0]        egr_valid,
  input  logic [NUM_EGR-1:0]        egr_ready,
  output logic                      err_sel,
  input  logic                      err_clr
);

  localparam int PAY_W = DATA_W + $bits(beat_t);

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic                r_err;
  logic                r_full;
  logic [DATA_W-1:0]   r_data;
  beat_t               r_beat;

  logic                w_bad;
  logic [SEL_W-1:0]    w_route_sel;
  beat_t               w_in_beat;
  logic                w_good_vld;
  logic                w_ing_rdy;
  logic                w_xfer;
  logic [NUM_EGR-1:0]  w_egr_valid;
  logic                w_pop;
  logic                w_st_vld;
  logic                w_st_rdy;
  logic [PAY_W-1:0]    w_st_pay;
  logic [DATA_W-1:0]   w_st_data;
  beat_t               w_st_beat;
  logic                w_load;

  // Select is only meaningful on a first beat; inside a packet the latched one is used.
  assign w_bad       = (r_state == IDLE) & ({1'b0, ing_sel} >= (SEL_W+1)'(NUM_EGR));
  assign w_route_sel = (r_state == PKT) ? r_sel : ing_sel;
  assign w_in_beat   = '{last: ing_last, sel: SEL_MAX_W'(w_route_sel)};
  assign w_good_vld  = ing_valid & (r_state != DROP) & ~w_bad;

  assign w_pop    = |(w_egr_valid & egr_ready);
  assign w_st_rdy = ~r_full | w_pop;

`ifdef AH_DEMUX_SKID_EN
  logic w_skid_rdy;

  ah_demux_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_in_dat  ({ing_data, w_in_beat}),
    .i_in_vld  (w_good_vld),
    .o_in_rdy  (w_skid_rdy),
    .o_out_dat (w_st_pay),
    .o_out_vld (w_st_vld),
    .i_out_rdy (w_st_rdy)
  );

  // Dropped beats never enter the skid, so DROP accepts unconditionally.
  assign w_ing_rdy = (r_state == DROP) | w_skid_rdy;
`else
  assign w_st_vld  = w_good_vld;
  assign w_st_pay  = {ing_data, w_in_beat};
  assign w_ing_rdy = ~rst & ((r_state == DROP) | w_st_rdy);
`endif

  assign w_st_data = w_st_pay[PAY_W-1 -: DATA_W];
  assign w_st_beat = w_st_pay[$bits(beat_t)-1:0];

  assign w_xfer = ing_valid & w_ing_rdy;
  // A push on a full stage is allowed only alongside a pop; the new beat replaces the old.
  assign w_load = w_st_vld & w_st_rdy;

  // Ingress-side FSM, select latch and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_xfer & w_bad) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
      if (w_xfer) begin
        case (r_state)
          IDLE: begin
            if (w_bad) begin
              if (!ing_last) r_state <= DROP;
            end else begin
              r_sel <= ing_sel;
              if (!ing_last) r_state <= PKT;
            end
          end
          PKT, DROP: begin
            if (ing_last) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Single-entry output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_beat <= '0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_data <= w_st_data;
      r_beat <= w_st_beat;
    end else if (w_pop) begin
      r_full <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_EGR; i++) begin : g_ch
    assign w_egr_valid[i]                = r_full & (r_beat.sel == SEL_MAX_W'(i));
    assign egr_last[i]                   = w_egr_valid[i] & r_beat.last;
    assign egr_data[i*DATA_W +: DATA_W] = r_data;
  end

  assign egr_valid = w_egr_valid;
  assign ing_ready = w_ing_rdy;
  assign err_sel   = r_err;

endmodule

// File: tb/tb_ah_demux_pkt.sv
// Self-checking bench for ah_demux_pkt: vector table of single-beat routes plus
// hand-written packet, stall, error, back-to-back and reset sequences; egress
// beats are checked against a scoreboard queue filled at ingress transfer time.
module tb_ah_demux_pkt;

  localparam int DW = 258;
  localparam int NE = 11;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DW-1:0]    ing_data = '0;
  logic             ing_valid = 1'b0;
  logic             ing_ready;
  logic [SW-1:0]    ing_sel = '0;
  logic             ing_last = 1'b0;
  logic [NE*DW-1:0] egr_data;
  logic [NE-1:0]    egr_last;
  logic [NE-1:0]    egr_valid;
  logic [NE-1:0]    egr_ready = '1;
  logic             err_sel;
  logic             err_clr = 1'b0;

  ah_demux_pkt #(.DATA_W(DW), .NUM_EGR(NE)) dut (
    .clk       (clk),
    .rst       (rst),
    .ing_data  (ing_data),
    .ing_valid (ing_valid),
    .ing_ready (ing_ready),
    .ing_sel   (ing_sel),
    .ing_last  (ing_last),
    .egr_data  (egr_data),
    .egr_last  (egr_last),
    .egr_valid (egr_valid),
    .egr_ready (egr_ready),
    .err_sel   (err_sel),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] d;
    logic [NE-1:0] exp_vld;
    logic          exp_err;
  } vec_t;

  typedef struct {
    int          ch;
    logic [DW-1:0] d;
    logic        l;
  } exp_t;

  exp_t sbq[$];
  int   passes = 0;
  int   total  = 0;
  int   m_state = 0;  // 0 idle, 1 in packet, 2 dropping
  int   m_sel   = 0;

  task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] mk(input int seed);
    logic [31:0] w;
    w = seed ^ 32'h5A5A0000;
    return {2'b10, {8{w}}};
  endfunction

  // Reference model of the ingress FSM: decides which beats should reach egress.
  task automatic model_push(input logic [SW-1:0] sel, input logic [DW-1:0] d, input logic l);
    exp_t e;
    if (m_state == 0) begin
      if (int'(sel) < NE) begin
        e.ch = int'(sel); e.d = d; e.l = l;
        sbq.push_back(e);
        m_sel   = int'(sel);
        m_state = l ? 0 : 1;
      end else begin
        m_state = l ? 0 : 2;
      end
    end else if (m_state == 1) begin
      e.ch = m_sel; e.d = d; e.l = l;
      sbq.push_back(e);
      if (l) m_state = 0;
    end else begin
      if (l) m_state = 0;
    end
  endtask

  // Called #1 after a posedge; returns #1 after the posedge of the transfer.
  task automatic send(input logic [SW-1:0] sel, input logic [DW-1:0] d, input logic l);
    logic got;
    ing_valid = 1'b1; ing_sel = sel; ing_data = d; ing_last = l;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (ing_ready) got = 1'b1;
    end
    if (!got) chk("send_timeout", 0, 1);
    else model_push(sel, d, l);
    @(posedge clk); #1;
    ing_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Egress monitor / scoreboard.
  always @(negedge clk) begin
    int   ch;
    exp_t e;
    if (!rst && ((egr_valid & egr_ready) != '0)) begin
      ch = 0;
      for (int i = 0; i < NE; i++) if (egr_valid[i]) ch = i;
      chk("onehot", $countones(egr_valid), 1);
      if (sbq.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sb_ch", ch, e.ch);
        chk("sb_data", egr_data[ch*DW +: DW], e.d);
        chk("sb_last", egr_last[ch], e.l);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    logic [DW-1:0]    d0;
    logic [NE-1:0]    b2b_exp[4];

    vt[0] = '{sel: 4'd3,  d: 258'h2A,  exp_vld: 11'h008, exp_err: 1'b0};
    vt[1] = '{sel: 4'd0,  d: mk(1),    exp_vld: 11'h001, exp_err: 1'b0};
    vt[2] = '{sel: 4'd10, d: mk(2),    exp_vld: 11'h400, exp_err: 1'b0};
    vt[3] = '{sel: 4'd12, d: mk(3),    exp_vld: 11'h000, exp_err: 1'b1};
    vt[4] = '{sel: 4'd1,  d: mk(4),    exp_vld: 11'h002, exp_err: 1'b1};
    vt[5] = '{sel: 4'd15, d: mk(5),    exp_vld: 11'h000, exp_err: 1'b1};

    // Reset state.
    #12;
    chk("rst_valid", egr_valid, 0);
    chk("rst_last", egr_last, 0);
    chk("rst_data_or", |egr_data, 0);
    chk("rst_err", err_sel, 0);
    chk("rst_ready", ing_ready, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", ing_ready, 1);

    // Single-beat routing table.
    for (int i = 0; i < 6; i++) begin
      send(vt[i].sel, vt[i].d, 1'b1);
      chk("tbl_valid", egr_valid, vt[i].exp_vld);
      if (vt[i].exp_vld != '0) chk("tbl_data", egr_data[int'(vt[i].sel)*DW +: DW], vt[i].d);
      chk("tbl_err", err_sel, vt[i].exp_err);
      idle(1);
    end

    // Packet: select latched on beat 0, later ing_sel ignored; then IDLE again.
    send(4'd5, mk(10), 1'b0);
    send(4'd2, mk(11), 1'b0);
    send(4'd2, mk(12), 1'b0);
    send(4'd2, mk(13), 1'b1);
    idle(1);
    send(4'd2, mk(14), 1'b1);
    chk("after_pkt_idle", egr_valid, 11'h004);
    idle(2);

    // Back-pressure on channel 5 mid-packet.
    egr_ready = '1; egr_ready[5] = 1'b0;
    fork
      begin
        send(4'd5, mk(20), 1'b0);
        send(4'd9, mk(21), 1'b0);
        send(4'd9, mk(22), 1'b0);
        send(4'd9, mk(23), 1'b1);
      end
      begin
        for (int n = 0; n < 50 && !egr_valid[5]; n++) @(negedge clk);
        chk("bp_seen", egr_valid[5], 1);
        d0 = egr_data[5*DW +: DW];
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_valid_hold", egr_valid, 11'h020);
          chk("bp_data_hold", egr_data[5*DW +: DW], d0);
`ifndef AH_DEMUX_SKID_EN
          chk("bp_ing_stall", ing_ready, 0);
`endif
        end
        @(posedge clk); #1;
        egr_ready = '1;
      end
    join
    idle(3);

    // Out-of-range select: whole packet swallowed, sticky error, clear, set-wins.
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("err_cleared0", err_sel, 0);
    send(4'd12, mk(30), 1'b0);
    chk("bad_err", err_sel, 1);
    chk("bad_valid0", egr_valid, 0);
    ing_valid = 1'b1; ing_sel = 4'd2; ing_data = mk(31); ing_last = 1'b1;
    @(negedge clk);
    chk("drop_rdy", ing_ready, 1);
    if (ing_ready) model_push(4'd2, mk(31), 1'b1);
    @(posedge clk); #1;
    ing_valid = 1'b0;
    chk("bad_valid1", egr_valid, 0);
    idle(1);
    chk("bad_valid2", egr_valid, 0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("err_cleared", err_sel, 0);
    err_clr = 1'b1;
    send(4'd13, mk(32), 1'b1);
    err_clr = 1'b0;
    chk("err_set_wins", err_sel, 1);
    idle(2);

    // Back-to-back single-beat packets, no bubble.
    b2b_exp[0] = 11'h001; b2b_exp[1] = 11'h002; b2b_exp[2] = 11'h400; b2b_exp[3] = 11'h001;
    fork
      begin
        send(4'd0,  mk(40), 1'b1);
        send(4'd1,  mk(41), 1'b1);
        send(4'd10, mk(42), 1'b1);
        send(4'd0,  mk(43), 1'b1);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #2;
          chk("b2b_valid", egr_valid, b2b_exp[k]);
        end
      end
    join
    idle(2);

    // Reset during beat 2 of a 4-beat packet.
    send(4'd4, mk(50), 1'b0);
    send(4'd4, mk(51), 1'b0);
    ing_valid = 1'b1; ing_sel = 4'd4; ing_data = mk(52); ing_last = 1'b0;
    #2; rst = 1'b1;
    #1;
    chk("midrst_valid", egr_valid, 0);
    chk("midrst_ready", ing_ready, 0);
    ing_valid = 1'b0;
    sbq.delete();
    m_state = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rdy_rel", ing_ready, 1);
    send(4'd7, mk(60), 1'b1);
    chk("midrst_route7", egr_valid, 11'h080);
    chk("midrst_data7", egr_data[7*DW +: DW], mk(60));
    idle(3);

    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
